// File: rtl/mem_test_seq.sv
// Host-end memory test sequencer: streams a write pass then a read pass over
// [0..ADDR_LAST] and checks the returned read data against PATTERN ^ addr[7:0].
module mem_test_seq #(
    parameter logic [15:0] ADDR_LAST = 16'h7FFF,
    parameter logic [7:0]  PATTERN   = 8'hA5,
    parameter int unsigned PKT_LEN   = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] seq2gtp_tdata,
    output logic        seq2gtp_tvalid,
    input  logic        seq2gtp_tready,
    output logic        seq2gtp_tlast,
    input  logic [31:0] gtp2seq_tdata,
    input  logic        gtp2seq_tvalid,
    output logic        gtp2seq_tready,
    input  logic        gtp2seq_tlast,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_addr
);

    localparam int unsigned PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0]  OP_WR = 2'b01;
    localparam logic [1:0]  OP_RD = 2'b10;

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  rsvd;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_word_t;

    typedef struct packed {
        logic [7:0]  rsvd;
        logic [15:0] addr;
        logic [7:0]  data;
    } rsp_word_t;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RSP, S_DONE} state_t;

    function automatic cmd_word_t make_cmd(input logic wr, input logic [15:0] a);
        cmd_word_t c;
        c.op   = wr ? OP_WR : OP_RD;
        c.rsvd = 6'h00;
        c.addr = a;
        c.data = wr ? (PATTERN ^ a[7:0]) : 8'h00;
        return c;
    endfunction

    function automatic logic word_is_last(input logic [PKT_W-1:0] p, input logic [15:0] a);
        return (p == PKT_W'(PKT_LEN - 1)) || (a == ADDR_LAST);
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    cmd_word_t        tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [15:0]      rsp_idx_q, rsp_idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      first_q, first_d;

    logic             cmd_fire;
    logic             in_check;
    logic             finish;
    logic             tmo_hit;
    logic [15:0]      addr_nxt;
    logic [PKT_W-1:0] pkt_nxt;
    rsp_word_t        exp_rsp;
    logic             unused_tlast;

    assign unused_tlast = gtp2seq_tlast;

    // Next-state, command generation and response checking
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pkt_d     = pkt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        rsp_idx_d = rsp_idx_q;
        tmo_d     = tmo_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        first_d   = first_q;
        finish    = 1'b0;
        tmo_hit   = 1'b0;

        cmd_fire  = tvalid_q & seq2gtp_tready;
        in_check  = (state_q == S_READ) || (state_q == S_WAIT_RSP);
        addr_nxt  = addr_q + 16'd1;
        pkt_nxt   = (pkt_q == PKT_W'(PKT_LEN - 1)) ? PKT_W'(0) : pkt_q + PKT_W'(1);
        exp_rsp.rsvd = 8'h00;
        exp_rsp.addr = rsp_idx_q;
        exp_rsp.data = PATTERN ^ rsp_idx_q[7:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WRITE;
                    addr_d    = 16'h0000;
                    pkt_d     = PKT_W'(0);
                    tvalid_d  = 1'b1;
                    tdata_d   = make_cmd(1'b1, 16'h0000);
                    tlast_d   = word_is_last(PKT_W'(0), 16'h0000);
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = 16'h0000;
                    first_d   = 16'h0000;
                    rsp_idx_d = 16'h0000;
                end
            end
            S_WRITE: begin
                if (cmd_fire) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d   = S_READ;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        rsp_idx_d = 16'h0000;
                    end else begin
                        addr_d  = addr_nxt;
                        pkt_d   = pkt_nxt;
                        tdata_d = make_cmd(1'b1, addr_nxt);
                        tlast_d = word_is_last(pkt_nxt, addr_nxt);
                    end
                end
            end
            S_READ: begin
                // First READ cycle is the idle gap between phases
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    addr_d   = 16'h0000;
                    pkt_d    = PKT_W'(0);
                    tdata_d  = make_cmd(1'b0, 16'h0000);
                    tlast_d  = word_is_last(PKT_W'(0), 16'h0000);
                end else if (cmd_fire) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d  = S_WAIT_RSP;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tmo_d    = TMO_W'(0);
                    end else begin
                        addr_d  = addr_nxt;
                        pkt_d   = pkt_nxt;
                        tdata_d = make_cmd(1'b0, addr_nxt);
                        tlast_d = word_is_last(pkt_nxt, addr_nxt);
                    end
                end
            end
            S_WAIT_RSP: begin
                if (!gtp2seq_tvalid) begin
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        tmo_hit = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_check && gtp2seq_tvalid) begin
            if (gtp2seq_tdata != exp_rsp) begin
                if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                if (err_q == 16'h0000) begin
                    first_d = rsp_idx_q;
                end
            end
            rsp_idx_d = rsp_idx_q + 16'd1;
            tmo_d     = TMO_W'(0);
            finish    = (rsp_idx_q == ADDR_LAST);
        end

        if (finish || tmo_hit) begin
            state_d   = S_DONE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = tmo_hit;
            pass_d    = (err_d == 16'h0000) && !tmo_hit;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 16'h0000;
            pkt_q     <= PKT_W'(0);
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            rsp_idx_q <= 16'h0000;
            tmo_q     <= TMO_W'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 16'h0000;
            first_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pkt_q     <= pkt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            rsp_idx_q <= rsp_idx_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign seq2gtp_tdata  = tdata_q;
    assign seq2gtp_tvalid = tvalid_q;
    assign seq2gtp_tlast  = tlast_q;
    assign gtp2seq_tready = 1'b1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;

endmodule
